arb16_rr: RTL and testbench



---
 rtl/arb16_pkg.sv | 12 +
 rtl/mux16.sv | 47 ++++
 rtl/arb16_rr.sv | 113 +++++++++++
 tb/tb_arb16_rr.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/arb16_pkg.sv
// Shared constants and state encoding for the arb16_rr round-robin arbiter.
package arb16_pkg;

  localparam int unsigned ARB_N     = 16;
  localparam int unsigned ARB_SEL_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mux16.sv
// 16:1 W-bit data multiplexer driven by a 4-bit select.
module mux16 #(
  parameter int unsigned W = 1
) (
  input  logic [3:0]   sel,
  input  logic [W-1:0] i0000,
  input  logic [W-1:0] i0001,
  input  logic [W-1:0] i0010,
  input  logic [W-1:0] i0011,
  input  logic [W-1:0] i0100,
  input  logic [W-1:0] i0101,
  input  logic [W-1:0] i0110,
  input  logic [W-1:0] i0111,
  input  logic [W-1:0] i1000,
  input  logic [W-1:0] i1001,
  input  logic [W-1:0] i1010,
  input  logic [W-1:0] i1011,
  input  logic [W-1:0] i1100,
  input  logic [W-1:0] i1101,
  input  logic [W-1:0] i1110,
  input  logic [W-1:0] i1111,
  output logic [W-1:0] o
);

  always_comb begin
    o = '0;
    case (sel)
      4'b0000: o = i0000;
      4'b0001: o = i0001;
      4'b0010: o = i0010;
      4'b0011: o = i0011;
      4'b0100: o = i0100;
      4'b0101: o = i0101;
      4'b0110: o = i0110;
      4'b0111: o = i0111;
      4'b1000: o = i1000;
      4'b1001: o = i1001;
      4'b1010: o = i1010;
      4'b1011: o = i1011;
      4'b1100: o = i1100;
      4'b1101: o = i1101;
      4'b1110: o = i1110;
      default: o = i1111;
    endcase
  end

endmodule

// File: rtl/arb16_rr.sv
// Round-robin arbiter sharing one W-bit valid/ready channel among 16 requesters.
// Optional packet locking (no interleave of multi-beat packets) under ARB16_PKT_LOCK_EN.
module arb16_rr
  import arb16_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ARB_N-1:0]     req,
  input  logic [ARB_N*W-1:0]   din,
  input  logic [ARB_N-1:0]     din_last,
  output logic [ARB_N-1:0]     gnt,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [W-1:0]         o_data,
  output logic                 o_last,
  output logic [ARB_SEL_W-1:0] o_sel
);

  arb_state_e           state_q, state_d;
  logic [ARB_SEL_W-1:0] sel_q, sel_d;
  logic [ARB_SEL_W-1:0] ptr_q, ptr_d;
  logic                 xfer;

  // First set request bit at or above p, searching upward modulo 16.
  function automatic logic [ARB_SEL_W-1:0] rr_pick(input logic [ARB_N-1:0] r,
                                                   input logic [ARB_SEL_W-1:0] p);
    logic [ARB_SEL_W-1:0] idx;
    logic                 found;
    rr_pick = p;
    found   = 1'b0;
    for (int unsigned k = 0; k < ARB_N; k++) begin
      idx = p + ARB_SEL_W'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign o_sel  = sel_q;
  assign o_last = din_last[sel_q];
  assign xfer   = o_valid & o_ready;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    gnt     = '0;
    o_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req != '0) begin
          sel_d   = rr_pick(req, ptr_q);
          state_d = ST_BUSY;
        end
      end
      default: begin
        o_valid = req[sel_q];
        if (xfer) begin
          gnt[sel_q] = 1'b1;
`ifdef ARB16_PKT_LOCK_EN
          if (o_last) begin
            ptr_d   = sel_q + 1'b1;
            state_d = ST_IDLE;
          end
`else
          ptr_d   = sel_q + 1'b1;
          state_d = ST_IDLE;
`endif
        end else if (!req[sel_q]) begin
          // Owner withdrew without a transfer: drop the grant, keep priority.
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  mux16 #(.W(W)) u_mux (
    .sel   (sel_q),
    .i0000 (din[0*W +: W]),
    .i0001 (din[1*W +: W]),
    .i0010 (din[2*W +: W]),
    .i0011 (din[3*W +: W]),
    .i0100 (din[4*W +: W]),
    .i0101 (din[5*W +: W]),
    .i0110 (din[6*W +: W]),
    .i0111 (din[7*W +: W]),
    .i1000 (din[8*W +: W]),
    .i1001 (din[9*W +: W]),
    .i1010 (din[10*W +: W]),
    .i1011 (din[11*W +: W]),
    .i1100 (din[12*W +: W]),
    .i1101 (din[13*W +: W]),
    .i1110 (din[14*W +: W]),
    .i1111 (din[15*W +: W]),
    .o     (o_data)
  );

endmodule

// File: tb/tb_arb16_rr.sv
// Directed self-checking bench for arb16_rr (W=8, din[i]=i*3).
module tb_arb16_rr;

  localparam int unsigned W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   req;
  logic [16*W-1:0] din;
  logic [15:0]   din_last;
  logic [15:0]   gnt;
  logic          o_valid;
  logic          o_ready;
  logic [W-1:0]  o_data;
  logic          o_last;
  logic [3:0]    o_sel;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  arb16_rr #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .din      (din),
    .din_last (din_last),
    .gnt      (gnt),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_last   (o_last),
    .o_sel    (o_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic expect_busy(input string tag, input int unsigned idx);
    @(negedge clk);
    check({tag, "_valid"}, 32'(o_valid), 32'd1);
    check({tag, "_sel"},   32'(o_sel),   32'(idx));
    check({tag, "_data"},  32'(o_data),  32'(idx * 3));
    check({tag, "_gnt"},   32'(gnt),     32'(1 << idx));
  endtask

  int unsigned g [4];
  int unsigned ng;
  int unsigned beats3;

  initial begin
    rst      = 1'b1;
    req      = '0;
    o_ready  = 1'b1;
    din_last = 16'h0001;
    for (int i = 0; i < 16; i++) din[i*W +: W] = W'(i * 3);

    // Reset values
    tick();
    @(negedge clk);
    check("rst_gnt",   32'(gnt),     32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_sel",   32'(o_sel),   32'd0);
    check("rst_data",  32'(o_data),  32'd0);
    check("rst_last",  32'(o_last),  32'd1);
    din_last = '0;

    // Single requester 0: latency 1, then IDLE with ptr=1
    do_reset();
    req = 16'h0001;
    tick();
    expect_busy("single", 0);
    tick();
    req = '0;
    @(negedge clk);
    check("single_idle_valid", 32'(o_valid), 32'd0);
    check("single_idle_gnt",   32'(gnt),     32'd0);
    req = 16'h0003;
    tick();
    expect_busy("single_ptr1", 1);
    tick();
    req = '0;

    // All requesting: 0..15, 0 at one beat per 2 cycles
    do_reset();
    req = 16'hFFFF;
    for (int k = 0; k < 17; k++) begin
      tick();
      expect_busy("rr", k % 16);
      tick();
      @(negedge clk);
      check("rr_gap", 32'(o_valid), 32'd0);
    end
    req = '0;

    // Wrap-around: ptr=15 then 15 wins, then 0
    do_reset();
    req = 16'h4000;
    tick();
    expect_busy("wrap_pre", 14);
    tick();
    req = 16'h8001;
    tick();
    expect_busy("wrap15", 15);
    tick();
    tick();
    expect_busy("wrap0", 0);
    tick();
    req = '0;

    // Backpressure on requester 7
    do_reset();
    o_ready = 1'b0;
    req = 16'h0080;
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      check("bp_valid", 32'(o_valid), 32'd1);
      check("bp_sel",   32'(o_sel),   32'd7);
      check("bp_data",  32'(o_data),  32'd21);
      check("bp_gnt",   32'(gnt),     32'd0);
    end
    tick();
    o_ready = 1'b1;
    @(negedge clk);
    check("bp_release_gnt", 32'(gnt), 32'h0080);
    tick();
    req = '0;
    @(negedge clk);
    check("bp_after_gnt", 32'(gnt), 32'd0);

    // Packet of 3 beats from requester 3 competing with requester 4
    do_reset();
    beats3 = 0;
    ng = 0;
    din_last = '0;
    req = 16'h0018;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        for (int i = 0; i < 16; i++)
          if (gnt[i] && ng < 4) begin
            g[ng] = i;
            ng++;
          end
        if (gnt[3]) beats3++;
      end
      tick();
      req[3]      = (beats3 < 3);
      din_last[3] = (beats3 == 2);
    end
    check("pkt_count", 32'(ng), 32'd4);
`ifdef ARB16_PKT_LOCK_EN
    check("pkt_g0", 32'(g[0]), 32'd3);
    check("pkt_g1", 32'(g[1]), 32'd3);
    check("pkt_g2", 32'(g[2]), 32'd3);
    check("pkt_g3", 32'(g[3]), 32'd4);
`else
    check("pkt_g0", 32'(g[0]), 32'd3);
    check("pkt_g1", 32'(g[1]), 32'd4);
    check("pkt_g2", 32'(g[2]), 32'd3);
    check("pkt_g3", 32'(g[3]), 32'd4);
`endif
    req = '0;
    din_last = '0;

    // Reset asserted while BUSY clears everything at once
    do_reset();
    req = 16'h0020;
    tick();
    expect_busy("mr_pre", 5);
    tick();
    req = 16'h0004;
    tick();
    #1;
    rst = 1'b1;
    #1;
    check("mr_gnt",   32'(gnt),     32'd0);
    check("mr_valid", 32'(o_valid), 32'd0);
    check("mr_sel",   32'(o_sel),   32'd0);
    check("mr_data",  32'(o_data),  32'd0);
    tick();
    rst = 1'b0;
    req = 16'h0082;
    tick();
    expect_busy("mr_restart", 1);
    tick();
    req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
